data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
- Parametrised next-generation data memory for the CPU datapath.
- Single-port synchronous storage with a valid/ready request interface and a registered one-cycle read response.
- Adds a zero-word op and a hardware whole-memory clear sweep driven by a small FSM.
- Sits between the load/store unit and storage; width, depth and address size are set per instance.

Parameters:
- DATA_W, 20, word width in bits
- ADDR_W, 10, address width
- DEPTH, 2**ADDR_W, number of words (must satisfy DEPTH <= 2**ADDR_W)

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- ReqValid  in  1  request present
- ReqReady  out  1  controller can accept a request this cycle
- ReqOp  in  2  00 load, 01 store, 10 zero-word, 11 reserved
- Address  in  ADDR_W  word address
- DataIn  in  DATA_W  store data
- RspValid  out  1  load data valid (one-cycle pulse)
- DataOut  out  DATA_W  load data
- ClearAll  in  1  request a full-memory zero sweep
- Busy  out  1  clear sweep in progress
- ParityErr  out  1  parity mismatch on the load response

Behaviour:
- Interface: one clock (Clock) and one asynchronous, active-high reset (Reset).
- Reset values: state IDLE, sweep counter 0, RspValid 0, DataOut 0, Busy 0, ParityErr 0. Reset does not initialise memory contents.
- FSM states: IDLE and CLEAR.
- ReqReady = (state==IDLE) && !ClearAll. It is combinational.
- A request is accepted on a rising edge where ReqValid && ReqReady.
- Load:
  - Accepted in cycle N; RspValid=1 in cycle N+1 only.
  - DataOut = mem[Address] as sampled at acceptance.
  - DataOut holds its last value while RspValid=0.
  - Back-to-back loads give one response per cycle.
- Store: mem[Address] <= DataIn at the accepting edge. No response.
- Zero-word: mem[Address] <= 0 at the accepting edge. No response.
- Reserved op: accepted, no effect, no response.
- Out-of-range Address (>= DEPTH): stores and zero-words are dropped; a load responds with DataOut=0.
- Load immediately after store to the same address returns the new data.
- ClearAll in IDLE:
  - Moves to CLEAR on the next edge. Busy=1 from that cycle.
  - ClearAll wins over a simultaneous ReqValid; that request is not accepted.
- CLEAR:
  - Writes 0 to mem[counter] each cycle; counter runs 0..DEPTH-1.
  - After the DEPTH-1 write, returns to IDLE and clears the counter.
  - Busy is high for exactly DEPTH cycles. ReqReady=0 throughout.
  - ClearAll asserted during CLEAR is ignored; it does not restart the sweep.
- A load accepted in the cycle ClearAll rises still produces its response in the next cycle.
- Reset during CLEAR: sweep aborts immediately and state returns to IDLE. Already-cleared words stay 0; the rest keep prior contents.

Optional Feature:
- Macro: DMEM_PARITY_EN
- Defined:
  - Each word stores one extra even-parity bit, computed on store and set to 0 on zero-word and clear.
  - ParityErr pulses together with RspValid when the recomputed parity differs from the stored bit.
  - Out-of-range loads never flag ParityErr.
- Undefined: no parity storage; ParityErr is tied to 0.

Decomposition:
- Package dmem_pkg:
  - Op encodings OP_LOAD, OP_STORE, OP_ZERO, OP_RSVD.
  - FSM state enum {IDLE, CLEAR}.
- Sub-module dmem_array:
  - Storage array with one write port and a synchronous read port.
  - Width DATA_W, or DATA_W+1 when parity is enabled.
  - The controller multiplexes the write address and data between request traffic and the sweep counter.

Test Plan:
- Reset, then store 0x0ABCD @5, then load @5 -> RspValid exactly one cycle after acceptance, DataOut=0x0ABCD. DataOut unchanged on the following idle cycle.
- Store 0x12345 @7, zero-word @7, load @7 -> DataOut=0x00000. Reserved op @7 -> no write, no RspValid.
- Fill addresses 0..3 with 0xFFFFF, pulse ClearAll with ReqValid high -> request not accepted, Busy high for 1024 cycles, ReqReady low throughout. Loads @0..3 then return 0.
- Assert Reset 100 cycles into a sweep -> Busy=0 and ReqReady=1 immediately. Address 50 reads 0; address 900 reads its pre-sweep value.
- With DEPTH=768, ADDR_W=10: store @800 then load @800 -> DataOut=0, memory unchanged.
- DMEM_PARITY_EN defined: store 0x00001 @9, flip stored data bit 0 by hierarchical deposit, load @9 -> ParityErr=1 with RspValid. An untouched word gives ParityErr=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: op encodings and sweep FSM states shared by the data memory controller
package dmem_pkg;
    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_STORE = 2'b01,
        OP_ZERO  = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-write-port storage with a registered read port
module dmem_array #(
    parameter int W     = 20,
    parameter int AW    = 10,
    parameter int DEPTH = 2**AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          rd_en,
    input  logic          rd_zero,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rd_data
);
    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rd_q, rd_d;
    // Out-of-range reads return zero instead of indexing past the array.
    always_comb rd_d = rd_en ? (rd_zero ? '0 : mem[raddr]) : rd_q;
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    always_ff @(posedge clk or posedge rst)
        if (rst) rd_q <= '0;
        else     rd_q <= rd_d;
    assign rd_data = rd_q;
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: valid/ready data memory with zero-word op and hardware clear sweep
// Define DMEM_PARITY_EN to store and check an even-parity bit per word.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W = 20,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic [1:0]        ReqOp,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] DataIn,
    output logic              RspValid,
    output logic [DATA_W-1:0] DataOut,
    input  logic              ClearAll,
    output logic              Busy,
    output logic              ParityErr
);
`ifdef DMEM_PARITY_EN
    localparam int W = DATA_W + 1;
`else
    localparam int W = DATA_W;
`endif
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              rsp_q, rsp_d;
    logic              accept, in_range, clearing, we;
    logic [ADDR_W-1:0] waddr;
    logic [W-1:0]      wdata, wr_word, rd_word;

    assign clearing = state_q == CLEAR;
    assign ReqReady = !clearing && !ClearAll;
    assign accept   = ReqValid && ReqReady;
    assign in_range = {1'b0, Address} < (ADDR_W+1)'(DEPTH);

`ifdef DMEM_PARITY_EN
    assign wr_word   = {^DataIn, DataIn};
    assign ParityErr = rsp_q && ^rd_word;
`else
    assign wr_word   = DataIn;
    assign ParityErr = 1'b0;
`endif

    // The sweep owns the write port; request writes only happen in IDLE.
    always_comb begin
        we    = clearing || (accept && in_range && (ReqOp == OP_STORE || ReqOp == OP_ZERO));
        waddr = clearing ? cnt_q : Address;
        wdata = (clearing || ReqOp == OP_ZERO) ? '0 : wr_word;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rsp_d   = accept && ReqOp == OP_LOAD;
        if (!clearing)
            state_d = ClearAll ? CLEAR : IDLE;
        else if (cnt_q == LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge Clock or posedge Reset)
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rsp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rsp_q   <= rsp_d;
        end

    dmem_array #(.W(W), .AW(ADDR_W), .DEPTH(DEPTH)) u_array (
        .clk     (Clock),
        .rst     (Reset),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .rd_en   (accept && ReqOp == OP_LOAD),
        .rd_zero (!in_range),
        .raddr   (Address),
        .rd_data (rd_word)
    );

    assign RspValid = rsp_q;
    assign DataOut  = rd_word[DATA_W-1:0];
    assign Busy     = clearing;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed self-checking bench for data_mem_ctrl
module tb_data_mem_ctrl;
    import dmem_pkg::*;

    logic        Clock = 1'b0, Reset = 1'b1;
    logic        ReqValid = 1'b0, ClearAll = 1'b0;
    logic [1:0]  ReqOp = 2'b00;
    logic [9:0]  Address = '0;
    logic [19:0] DataIn = '0;
    logic        ReqReady, RspValid, Busy, ParityErr;
    logic [19:0] DataOut;
    logic        s_ready, s_rsp, s_busy, s_perr;
    logic [19:0] s_dout;
    int          n_chk = 0, n_err = 0;

    always #5 Clock = ~Clock;

    data_mem_ctrl u_dut (
        .Clock(Clock), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqOp(ReqOp), .Address(Address), .DataIn(DataIn), .RspValid(RspValid),
        .DataOut(DataOut), .ClearAll(ClearAll), .Busy(Busy), .ParityErr(ParityErr)
    );

    data_mem_ctrl #(.DATA_W(20), .ADDR_W(10), .DEPTH(768)) u_small (
        .Clock(Clock), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(s_ready),
        .ReqOp(ReqOp), .Address(Address), .DataIn(DataIn), .RspValid(s_rsp),
        .DataOut(s_dout), .ClearAll(1'b0), .Busy(s_busy), .ParityErr(s_perr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [9:0] a, input logic [19:0] d);
        ReqValid = 1'b1; ReqOp = op; Address = a; DataIn = d;
        @(posedge Clock); @(negedge Clock);
        ReqValid = 1'b0;
    endtask

    task automatic load_chk(input string tag, input logic [9:0] a, input logic [19:0] exp);
        drive(OP_LOAD, a, '0);
        check({tag, "_rv"}, RspValid, 1);
        check(tag, DataOut, exp);
        check({tag, "_perr"}, ParityErr, 0);
    endtask

    initial begin
        int cnt, bad;
        repeat (2) @(negedge Clock);
        check("rst_rv", RspValid, 0);
        check("rst_dout", DataOut, 0);
        check("rst_busy", Busy, 0);
        check("rst_perr", ParityErr, 0);
        Reset = 1'b0;
        @(negedge Clock);
        check("rst_ready", ReqReady, 1);

        drive(OP_STORE, 10'd5, 20'h0ABCD);
        load_chk("ld5", 10'd5, 20'h0ABCD);
        @(negedge Clock);
        check("hold_rv", RspValid, 0);
        check("hold_dout", DataOut, 20'h0ABCD);

        drive(OP_STORE, 10'd7, 20'h12345);
        drive(OP_ZERO, 10'd7, 20'h12345);
        load_chk("zero7", 10'd7, 20'h00000);
        drive(OP_STORE, 10'd7, 20'h13579);
        drive(OP_RSVD, 10'd7, 20'hFFFFF);
        check("rsvd_rv", RspValid, 0);
        load_chk("rsvd7", 10'd7, 20'h13579);

        ReqValid = 1'b1; ReqOp = OP_LOAD; Address = 10'd5;
        @(posedge Clock); @(negedge Clock);
        Address = 10'd7;
        check("b2b_rv0", RspValid, 1);
        check("b2b_d0", DataOut, 20'h0ABCD);
        @(posedge Clock); @(negedge Clock);
        ReqValid = 1'b0;
        check("b2b_rv1", RspValid, 1);
        check("b2b_d1", DataOut, 20'h13579);

        drive(OP_STORE, 10'd3, 20'h2468A);
        load_chk("raw3", 10'd3, 20'h2468A);

        drive(OP_STORE, 10'd767, 20'h33333);
        drive(OP_STORE, 10'd800, 20'h77777);
        drive(OP_LOAD, 10'd800, '0);
        check("oor_rv", s_rsp, 1);
        check("oor_dout", s_dout, 0);
        check("oor_perr", s_perr, 0);
        check("big800", DataOut, 20'h77777);
        drive(OP_LOAD, 10'd767, '0);
        check("edge767", s_dout, 20'h33333);

        for (int i = 0; i < 4; i++) drive(OP_STORE, 10'(i), 20'hFFFFF);
        ClearAll = 1'b1; ReqValid = 1'b1; ReqOp = OP_LOAD; Address = 10'd0;
        #1 check("clr_ready", ReqReady, 0);
        @(posedge Clock); @(negedge Clock);
        ClearAll = 1'b0; ReqValid = 1'b0;
        check("clr_norsp", RspValid, 0);
        cnt = 0; bad = 0;
        while (Busy && cnt < 2000) begin
            cnt++;
            if (ReqReady) bad++;
            ClearAll = (cnt == 500);
            @(negedge Clock);
        end
        ClearAll = 1'b0;
        check("busy_len", cnt, 1024);
        check("busy_ready", bad, 0);
        check("post_ready", ReqReady, 1);
        for (int i = 0; i < 4; i++) load_chk("clr_ld", 10'(i), 20'h0);

        drive(OP_STORE, 10'd50, 20'h22222);
        drive(OP_STORE, 10'd900, 20'h11111);
        ClearAll = 1'b1;
        @(posedge Clock); @(negedge Clock);
        ClearAll = 1'b0;
        repeat (100) @(negedge Clock);
        check("mid_busy", Busy, 1);
        Reset = 1'b1;
        #1;
        check("abort_busy", Busy, 0);
        check("abort_ready", ReqReady, 1);
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        load_chk("abort50", 10'd50, 20'h0);
        load_chk("abort900", 10'd900, 20'h11111);

`ifdef DMEM_PARITY_EN
        drive(OP_STORE, 10'd9, 20'h00001);
        u_dut.u_array.mem[9][0] = 1'b0;
        drive(OP_LOAD, 10'd9, '0);
        check("par_rv", RspValid, 1);
        check("par_err", ParityErr, 1);
        load_chk("par_ok", 10'd900, 20'h11111);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
